// File: rtl/spi_main.sv
// spi_main: SPI initiator that shifts out {op,addr,data} and captures the reply frame.
// Define SPI_MAIN_ECHO_CHECK_EN to flag replies whose echo differs from the request.
module spi_main #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int TA_CYCLES  = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [2+ADDR_W+DATA_W-1:0]   rsp_frame,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         cs_n,
  output logic                         mosi,
  input  logic                         miso
);

  localparam int FW   = 2 + ADDR_W + DATA_W;
  localparam int M1   = (TA_CYCLES > GAP_CYCLES) ? TA_CYCLES : GAP_CYCLES;
  localparam int MAXC = (FW > M1) ? FW : M1;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] FW_LD  = CW'(FW - 1);
  localparam logic [CW-1:0] TA_LD  = CW'(TA_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_TURN,
    S_RESP,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] tx_q, tx_d;
  logic [FW-2:0] rx_q, rx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          valid_q, valid_d;
  logic          cs_n_q, mosi_q;
  logic [FW-1:0] cap;
  logic          last;
  logic          done;

  assign cap  = {rx_q, miso};
  assign last = (cnt_q == '0);
  assign done = (state_q == S_RESP) && last;

  // tx_q rotates rather than shifts, so after FW bits it holds the request again
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_CMD;
          cnt_d   = FW_LD;
          tx_d    = {req_op, req_addr, req_wdata};
        end
      end
      S_CMD: begin
        tx_d  = {tx_q[FW-2:0], tx_q[FW-1]};
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_TURN;
          cnt_d   = TA_LD;
        end
      end
      S_TURN: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_RESP;
          cnt_d   = FW_LD;
        end
      end
      S_RESP: begin
        rx_d  = cap[FW-2:0];
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
          frame_d = cap;
          valid_d = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(negedge sclk) begin
    cs_n_q <= (state_q == S_IDLE) || (state_q == S_GAP);
    mosi_q <= (state_q == S_CMD) && tx_q[FW-1];
  end

`ifdef SPI_MAIN_ECHO_CHECK_EN
  logic err_q, err_d;
  logic hdr_bad, data_bad;

  assign hdr_bad  = cap[FW-1:DATA_W] != tx_q[FW-1:DATA_W];
  assign data_bad = (tx_q[FW-1:FW-2] == 2'b01) &&
                    (cap[DATA_W-1:0] != tx_q[DATA_W-1:0]);

  always_comb begin
    err_d = err_q;
    if (done) err_d = hdr_bad || data_bad;
  end

  always_ff @(posedge sclk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = valid_q;
  assign rsp_frame = frame_q;
  assign rsp_data  = frame_q[DATA_W-1:0];
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_main.sv
// tb_spi_main: random and directed requests against a behavioural sub and
// a transaction-level reference of memory contents and frame timing.
module tb_spi_main;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int TA  = 2;
  localparam int GAP = 2;
  localparam int FW  = 2 + AW + DW;
  localparam int LAT = 2 * FW + TA;
  localparam int PER = LAT + GAP + 1;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [FW-1:0] rsp_frame;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          cs_n;
  logic          mosi;
  logic          miso = 1'b0;

  spi_main #(
    .ADDR_W(AW), .DATA_W(DW), .TA_CYCLES(TA), .GAP_CYCLES(GAP)
  ) dut (
    .sclk(sclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_frame(rsp_frame),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    int            acc;
    bit            flip;
  } req_t;

  req_t          pend[$];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] sub_mem [1024];
  logic [FW-1:0] last_exp = '0;
  int            cyc = 0;
  int            rsp_cnt = 0;
  int            nexp = 0;
  bit            flip_op = 1'b0;
  bit            b2b_chk = 1'b0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = '0;
      sub_mem[i] = '0;
    end
  end

  initial forever begin
    @(posedge sclk);
    cyc++;
  end

  // behavioural sub: sample command on posedges, drive reply on negedges
  int            k = 0;
  logic [FW-1:0] cmd = '0;
  logic [FW-1:0] resp = '0;

  initial forever begin
    logic [FW-1:0] c;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge sclk);
    if (cs_n !== 1'b0) k = 0;
    else begin
      k++;
      if (k <= FW) cmd = {cmd[FW-2:0], mosi};
      if (k == FW) begin
        c  = cmd;
        op = c[FW-1:FW-2];
        a  = c[FW-3:DW];
        d  = c[DW-1:0];
        if (op == 2'b01) sub_mem[a] = d;
        if (op == 2'b00) d = sub_mem[a];
        resp = {op, a, d};
        if (flip_op) resp[FW-1] = ~resp[FW-1];
      end
    end
  end

  initial forever begin
    int j;
    @(negedge sclk);
    j = k - FW - TA;
    miso = (j >= 0 && j < FW) ? resp[FW-1-j] : 1'b0;
  end

  // response scoreboard
  initial forever begin
    req_t          e;
    req_t          r;
    logic [DW-1:0] dexp;
    logic [FW-1:0] fexp;
    bit            eexp;
    bit            prev_v;
    @(negedge sclk);
    if (rst) pend.delete();
    else begin
      if (rsp_valid) begin
        rsp_cnt++;
        chk("rsp_1cyc", prev_v, 1'b0);
        if (pend.size() == 0) chk("rsp_unexp", rsp_valid, 1'b0);
        else begin
          e = pend.pop_front();
          if (e.op == 2'b00) dexp = ref_mem[e.addr];
          else dexp = e.d;
          if (e.op == 2'b01) ref_mem[e.addr] = e.d;
          fexp = {e.op, e.addr, dexp};
          if (e.flip) fexp[FW-1] = ~fexp[FW-1];
`ifdef SPI_MAIN_ECHO_CHECK_EN
          eexp = e.flip;
`else
          eexp = 1'b0;
`endif
          chk("rsp_lat", cyc - e.acc, LAT);
          chk("rsp_frame", rsp_frame, fexp);
          chk("rsp_data", rsp_data, fexp[DW-1:0]);
          chk("rsp_err", rsp_err, eexp);
          last_exp = fexp;
        end
      end
      if (req_valid && req_ready) begin
        r.op   = req_op;
        r.addr = req_addr;
        r.d    = req_wdata;
        r.acc  = cyc + 1;
        r.flip = flip_op;
        pend.push_back(r);
      end
    end
    prev_v = rsp_valid;
  end

  // chip-select run lengths
  int lowcnt = 0;
  int highcnt = 0;
  bit abort = 1'b0;

  initial forever begin
    @(posedge sclk);
    if (rst && cs_n === 1'b0) abort = 1'b1;
    if (cs_n === 1'b0) begin
      if (highcnt > 0 && b2b_chk) chk("cs_gap", highcnt, GAP + 1);
      highcnt = 0;
      lowcnt++;
    end else begin
      if (lowcnt > 0 && !abort) chk("cs_low", lowcnt, LAT);
      if (lowcnt > 0) abort = 1'b0;
      lowcnt = 0;
      highcnt++;
    end
  end

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit hold,
                      output int acc);
    int n;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge sclk);
      n++;
    end
    if (!req_ready) begin
      chk("acc_to", req_ready, 1'b1);
      req_valid = 1'b0;
      acc = -1;
      @(posedge sclk);
      #1;
      return;
    end
    @(posedge sclk);
    #1;
    acc = cyc;
    nexp++;
    if (!hold) begin
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
    end
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 400) begin
      @(negedge sclk);
      n++;
    end
    chk("rsp_to", rsp_cnt, target);
    @(posedge sclk);
    #1;
  endtask

  initial begin
    int            a;
    int            prev;
    logic [AW-1:0] ba [4];
    logic [DW-1:0] bd [4];
    logic [1:0]    op;
    ba = '{10'h001, 10'h002, 10'h155, 10'h2AA};
    bd = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA};
    prev = 0;

    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame", rsp_frame, '0);
    chk("rst_err", rsp_err, 1'b0);
    @(posedge sclk);
    #1;
    rst = 1'b0;
    @(negedge sclk);
    chk("ready_after_rst", req_ready, 1'b1);
    @(posedge sclk);
    #1;

    send(2'b01, 10'h000, 32'h1111_1111, 1'b0, a);
    wait_rsp(nexp);
    send(2'b01, 10'h3FF, 32'h2222_2222, 1'b0, a);
    wait_rsp(nexp);
    send(2'b00, 10'h3FF, $urandom, 1'b0, a);
    wait_rsp(nexp);
    send(2'b00, 10'h000, $urandom, 1'b0, a);
    wait_rsp(nexp);
    repeat (5) @(posedge sclk);
    #1;
    chk("rsp_hold", rsp_frame, last_exp);

    for (int i = 0; i < 4; i++) begin
      send(2'b01, ba[i], bd[i], i < 3, a);
      if (i > 0) chk("acc_gap", a - prev, PER);
      if (i == 1) b2b_chk = 1'b1;
      prev = a;
    end
    wait_rsp(nexp);
    b2b_chk = 1'b0;

    send(2'b01, 10'h155, $urandom, 1'b0, a);
    nexp--;
    while (cyc < a + 29) @(posedge sclk);
    #1;
    rst = 1'b1;
    @(posedge sclk);
    #1;
    @(negedge sclk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b0);
    @(posedge sclk);
    #1;
    chk("mid_rst_cs_n", cs_n, 1'b1);
    chk("mid_rst_mosi", mosi, 1'b0);
    rst = 1'b0;
    repeat (100) @(posedge sclk);
    #1;
    chk("mid_rst_no_rsp", rsp_cnt, nexp);
    send(2'b00, 10'h155, $urandom, 1'b0, a);
    wait_rsp(nexp);

    flip_op = 1'b1;
    send(2'b01, AW'($urandom_range(0, 7)), $urandom, 1'b0, a);
    wait_rsp(nexp);
    flip_op = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 7) == 0) op = 2'($urandom_range(2, 3));
      else op = 2'($urandom_range(0, 1));
      send(op, AW'($urandom_range(0, 7)), $urandom, 1'b0, a);
    end
    wait_rsp(nexp);
    chk("pend_empty", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
